// File: rtl/grant_holder.sv
// -----------------------------------------------------------------------------
// grant_holder
//
// Captures a one-hot grant from an upstream priority selector and holds
// ownership for that source until it reports that its transaction is done.
// Ownership passes through IDLE -> OWNED -> RELEASE -> IDLE. RELEASE is a
// one-cycle bubble, so a new grant is captured at the earliest three cycles
// after the previous one. Every output is a flop.
//
// Parameters
//   W_INPUT   number of sources, width of gnt (>= 2)
//   W_INDEX   width of idx, must equal clog2(W_INPUT)
//   W_CNT     width of the saturating hold-cycle counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   gnt        grant vector, at most one bit set when well-formed
//   gnt_valid  gnt is meaningful this cycle
//   xfer_done  owner has finished; honoured only while OWNED
//   gnt_ack    one-cycle pulse after a grant is captured
//   idx        binary index of the owner; kept after release
//   idx_valid  idx names a current owner
//   rel_pulse  one-cycle pulse after ownership is released
//   hold_cnt   cycles spent in the current or most recent ownership
//   gnt_err    sticky malformed-grant flag
//
// Build option
//   GRANT_HOLDER_ONEHOT_CHECK_EN  when defined, a multi-hot grant in IDLE is
//   refused and sets gnt_err until reset. When undefined, the least
//   significant set bit wins and gnt_err is tied low.
// -----------------------------------------------------------------------------
module grant_holder #(
   parameter int W_INPUT = 8,
   parameter int W_INDEX = 3,
   parameter int W_CNT   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [W_INPUT-1:0] gnt,
   input  logic               gnt_valid,
   input  logic               xfer_done,
   output logic               gnt_ack,
   output logic [W_INDEX-1:0] idx,
   output logic               idx_valid,
   output logic               rel_pulse,
   output logic [W_CNT-1:0]   hold_cnt,
   output logic               gnt_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWNED   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               capture;
   logic               release_now;
   logic [W_INDEX-1:0] lsb_idx;

   // Lowest set bit wins. The loop runs from the top down so the last match
   // it sees is the least significant one.
   always_comb begin
      lsb_idx = '0;
      for (int i = W_INPUT - 1; i >= 0; i--) begin
         if (gnt[i]) lsb_idx = W_INDEX'(i);
      end
   end

`ifdef GRANT_HOLDER_ONEHOT_CHECK_EN
   logic multi_hot;
   logic err_set;

   // Clearing the lowest set bit leaves something behind only if more than
   // one bit was set.
   assign multi_hot = |(gnt & (gnt - W_INPUT'(1)));
   assign err_set   = (state == IDLE) && gnt_valid && multi_hot;
`endif

   // Next-state logic and the capture/release strobes that feed the output
   // registers.
   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no
      // path leaves it unassigned and no latch is inferred.
      state_nxt   = state;
      capture     = 1'b0;
      release_now = 1'b0;
      unique case (state)
         IDLE: begin
`ifdef GRANT_HOLDER_ONEHOT_CHECK_EN
            if (gnt_valid && (|gnt) && !multi_hot) begin
`else
            if (gnt_valid && (|gnt)) begin
`endif
               capture   = 1'b1;
               state_nxt = OWNED;
            end
         end
         OWNED: begin
            if (xfer_done) begin
               release_now = 1'b1;
               state_nxt   = RELEASE;
            end
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge and evaluation order does not
      // matter.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Output registers. The reset is sampled on the clock edge only, so a
   // reset pulse between edges has no effect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_ack   <= 1'b0;
         rel_pulse <= 1'b0;
         idx       <= '0;
         idx_valid <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         gnt_ack   <= capture;
         rel_pulse <= release_now;
         if (capture) begin
            idx       <= lsb_idx;
            idx_valid <= 1'b1;
         end else if (release_now) begin
            idx_valid <= 1'b0;
         end
         // Every edge taken in OWNED counts, including the releasing edge.
         // The count saturates and holds through RELEASE and IDLE.
         if (capture)
            hold_cnt <= '0;
         else if ((state == OWNED) && (hold_cnt != {W_CNT{1'b1}}))
            hold_cnt <= hold_cnt + W_CNT'(1);
      end
   end

`ifdef GRANT_HOLDER_ONEHOT_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)       gnt_err <= 1'b0;
      else if (err_set) gnt_err <= 1'b1;
   end
`else
   assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_holder.sv
// -----------------------------------------------------------------------------
// tb_grant_holder
//
// Drives grant_holder with directed vectors. Two instances share the same
// inputs: the default build and one with W_CNT = 4, which lets the bench
// observe counter saturation on the narrow instance.
//
// The stimulus pushes the expected gnt_ack and rel_pulse events into a
// queue. A separate monitor pops an entry on every event the DUT shows and
// compares it. Static output values are checked directly.
// -----------------------------------------------------------------------------
module tb_grant_holder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] gnt;
   logic       gnt_valid;
   logic       xfer_done;

   logic       gnt_ack,   s_gnt_ack;
   logic [2:0] idx,       s_idx;
   logic       idx_valid, s_idx_valid;
   logic       rel_pulse, s_rel_pulse;
   logic [7:0] hold_cnt;
   logic [3:0] s_hold_cnt;
   logic       gnt_err,   s_gnt_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       is_rel;
      logic [2:0] idx;
      logic [7:0] cnt;
      logic [3:0] cnt_s;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   grant_holder #(.W_INPUT(8), .W_INDEX(3), .W_CNT(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .xfer_done (xfer_done),
      .gnt_ack   (gnt_ack),
      .idx       (idx),
      .idx_valid (idx_valid),
      .rel_pulse (rel_pulse),
      .hold_cnt  (hold_cnt),
      .gnt_err   (gnt_err)
   );

   grant_holder #(.W_INPUT(8), .W_INDEX(3), .W_CNT(4)) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .xfer_done (xfer_done),
      .gnt_ack   (s_gnt_ack),
      .idx       (s_idx),
      .idx_valid (s_idx_valid),
      .rel_pulse (s_rel_pulse),
      .hold_cnt  (s_hold_cnt),
      .gnt_err   (s_gnt_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic is_rel, input logic [2:0] i,
                       input logic [7:0] c, input logic [3:0] cs);
      exp_t e;
      e.is_rel = is_rel;
      e.idx    = i;
      e.cnt    = c;
      e.cnt_s  = cs;
      sb.push_back(e);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (gnt_ack === 1'b1 || rel_pulse === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_event", {30'd0, gnt_ack, rel_pulse}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("event_kind", {30'd0, gnt_ack, rel_pulse}, e.is_rel ? 32'd1 : 32'd2);
            check("event_idx", {29'd0, idx}, {29'd0, e.idx});
            check("event_idx_valid", {31'd0, idx_valid}, e.is_rel ? 32'd0 : 32'd1);
            check("event_hold_cnt", {24'd0, hold_cnt}, {24'd0, e.cnt});
            check("event_hold_cnt_w4", {28'd0, s_hold_cnt}, {28'd0, e.cnt_s});
            check("event_w4_pulses", {30'd0, s_gnt_ack, s_rel_pulse}, {30'd0, gnt_ack, rel_pulse});
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt_ack"},   {31'd0, gnt_ack},   32'd0);
      check({tag, "_idx"},       {29'd0, idx},       32'd0);
      check({tag, "_idx_valid"}, {31'd0, idx_valid}, 32'd0);
      check({tag, "_rel_pulse"}, {31'd0, rel_pulse}, 32'd0);
      check({tag, "_hold_cnt"},  {24'd0, hold_cnt},  32'd0);
      check({tag, "_gnt_err"},   {31'd0, gnt_err},   32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      gnt       = '0;
      gnt_valid = 1'b0;
      xfer_done = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Capture gnt = 0000_0100. An xfer_done in the capture cycle is ignored.
      gnt = 8'b0000_0100; gnt_valid = 1'b1; xfer_done = 1'b1;
      push(1'b0, 3'd2, 8'd0, 4'd0);
      tick();
      gnt = '0; gnt_valid = 1'b0; xfer_done = 1'b0;
      check("cap_idx_valid", {31'd0, idx_valid}, 32'd1);
      tick();
      check("ack_one_cycle", {31'd0, gnt_ack}, 32'd0);
      check("still_owned", {31'd0, idx_valid}, 32'd1);

      // Owned for 5 cycles, then released.
      tick(); tick(); tick();
      xfer_done = 1'b1;
      push(1'b1, 3'd2, 8'd5, 4'd5);
      tick();
      xfer_done = 1'b0;
      check("rel_idx_kept", {29'd0, idx}, 32'd2);
      // A grant offered during RELEASE is ignored; the same grant is taken
      // on the next cycle.
      gnt = 8'h80; gnt_valid = 1'b1;
      tick();
      check("release_bubble_no_ack", {31'd0, gnt_ack}, 32'd0);
      check("release_bubble_idx", {29'd0, idx}, 32'd2);
      push(1'b0, 3'd7, 8'd0, 4'd0);
      tick();
      gnt = '0; gnt_valid = 1'b0;

      // Hold for 20 cycles: the W_CNT=4 instance saturates at 15.
      for (int i = 0; i < 19; i++) tick();
      xfer_done = 1'b1;
      push(1'b1, 3'd7, 8'd20, 4'd15);
      tick();
      xfer_done = 1'b0;
      tick();
      tick();
      check("hold_cnt_held_idle", {24'd0, hold_cnt}, 32'd20);
      check("hold_cnt_w4_held_idle", {28'd0, s_hold_cnt}, 32'd15);
      check("idx_kept_idle", {29'd0, idx}, 32'd7);

      // Multi-hot grant 0011_0000.
      gnt = 8'b0011_0000; gnt_valid = 1'b1;
`ifdef GRANT_HOLDER_ONEHOT_CHECK_EN
      tick();
      tick();
      gnt = '0; gnt_valid = 1'b0;
      check("multi_no_capture", {31'd0, idx_valid}, 32'd0);
      check("multi_err_set", {31'd0, gnt_err}, 32'd1);
      tick();
      tick();
      check("multi_err_sticky", {31'd0, gnt_err}, 32'd1);
`else
      push(1'b0, 3'd4, 8'd0, 4'd0);
      tick();
      gnt = '0; gnt_valid = 1'b0;
      check("multi_lsb_idx", {29'd0, idx}, 32'd4);
      check("multi_err_zero", {31'd0, gnt_err}, 32'd0);
      xfer_done = 1'b1;
      push(1'b1, 3'd4, 8'd1, 4'd1);
      tick();
      xfer_done = 1'b0;
      tick();
      tick();
`endif

      // Capture idx 3, then reset in the middle of OWNED.
      gnt = 8'b0000_1000; gnt_valid = 1'b1;
      push(1'b0, 3'd3, 8'd0, 4'd0);
      tick();
      gnt = '0; gnt_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      check("sync_rst_no_effect_valid", {31'd0, idx_valid}, 32'd1);
      check("sync_rst_no_effect_idx", {29'd0, idx}, 32'd3);
      tick();
      rst_n = 1'b1;
      check_all_zero("mid_owned_reset");
      xfer_done = 1'b1;
      tick();
      tick();
      xfer_done = 1'b0;
      check("post_reset_no_rel", {31'd0, rel_pulse}, 32'd0);
      check("post_reset_idle", {31'd0, idx_valid}, 32'd0);
      tick();
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
